// File: rtl/grant_decoder_pkg.sv
// Shared types and helpers for the grant decoder.
// Holds the FSM encoding and a ceil-log2 used by encoder/decoder pairs.
package grant_decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int log2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/grant_watchdog.sv
// Saturating grant-age counter.
// Flags expiry while enabled and the count has reached the limit.
module grant_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable & (count == limit);

endmodule

// File: rtl/grant_decoder.sv
// Registered one-hot grant decoder with valid/ready intake,
// per-port release and optional watchdog.
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int INPUT_WIDTH   = 3,
  parameter int NUM_OUTPUTS   = 2**INPUT_WIDTH,
  parameter int TIMEOUT       = 0,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INPUT_WIDTH-1:0] encoded_input,
  input  logic                   in_valid,
  output logic                   in_rdy,
  output logic [0:NUM_OUTPUTS-1] decoded_output,
  output logic                   grant_active,
  input  logic [0:NUM_OUTPUTS-1] done,
  output logic                   error,
  output logic                   timeout
);

  state_t                 state;
  logic [INPUT_WIDTH-1:0] sel;
  logic [0:NUM_OUTPUTS-1] dec_d;
  logic                   done_sel;
  logic                   wd_hit;
  logic                   expire;
  logic                   rel;
  logic                   accept;
  logic                   in_range;
  logic                   load;

  generate
    if (NUM_OUTPUTS == 2**INPUT_WIDTH) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range =
        encoded_input < INPUT_WIDTH'(NUM_OUTPUTS);
    end
  endgenerate

  always_comb begin
    dec_d = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      dec_d[i] = (encoded_input == INPUT_WIDTH'(i));
  end

  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if (sel == INPUT_WIDTH'(i)) done_sel = done[i];
  end

  // done on the granted port beats a coincident expiry
  assign expire = (state == GRANT) & wd_hit & ~done_sel;
  assign rel    = (state == GRANT) & (done_sel | wd_hit);
  assign in_rdy = (state == IDLE) | rel;
  assign accept = in_valid & in_rdy;
  assign load   = accept & in_range;

  generate
    if (TIMEOUT > 0) begin : g_wd
      grant_watchdog #(
        .WIDTH(TIMEOUT_WIDTH)
      ) u_wd (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (load | rel),
        .enable (state == GRANT),
        .limit  (TIMEOUT_WIDTH'(TIMEOUT - 1)),
        .expired(wd_hit)
      );
    end else begin : g_no_wd
      assign wd_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      sel            <= '0;
      decoded_output <= '0;
      grant_active   <= 1'b0;
      error          <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      error   <= accept & ~in_range;
      timeout <= expire;
      if (load) begin
        state          <= GRANT;
        sel            <= encoded_input;
        decoded_output <= dec_d;
        grant_active   <= 1'b1;
      end else if (rel) begin
        state          <= IDLE;
        decoded_output <= '0;
        grant_active   <= 1'b0;
      end
    end
  end

endmodule
